// File: rtl/dp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dp_ctrl_pkg
// Shared definitions for the datapath issue controller:
//   - instruction class encodings and field bit positions
//   - HALT alu_sel code
//   - issue FSM state enum
//   - datapath control bundle and the decode helpers that build it
// ---------------------------------------------------------------------------
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        ClsNop   = 2'b00,
        ClsAlu   = 2'b01,
        ClsLoad  = 2'b10,
        ClsStore = 2'b11
    } instr_cls_e;

    localparam int unsigned ClsMsb  = 31;
    localparam int unsigned ClsLsb  = 30;
    localparam int unsigned AluMsb  = 29;
    localparam int unsigned AluLsb  = 26;
    localparam int unsigned RdMsb   = 25;
    localparam int unsigned RdLsb   = 21;
    localparam int unsigned Rs1Msb  = 20;
    localparam int unsigned Rs1Lsb  = 16;
    localparam int unsigned Rs2Msb  = 15;
    localparam int unsigned Rs2Lsb  = 11;
    localparam int unsigned AddrMsb = 7;
    localparam int unsigned AddrLsb = 0;

    localparam logic [3:0] HaltAluSel = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic       reg_write_en;
        logic [3:0] alu_sel;
        logic [7:0] mem_addr;
        logic       mem_write_en;
        logic       mem_read_en;
        logic       wb_data_sel;
    } dp_ctrl_t;

    function automatic instr_cls_e get_cls(logic [31:0] w);
        return instr_cls_e'(w[ClsMsb:ClsLsb]);
    endfunction

    function automatic logic is_halt(logic [31:0] w);
        return (get_cls(w) == ClsNop) && (w[AluMsb:AluLsb] == HaltAluSel);
    endfunction

    function automatic logic reads_rs1(logic [31:0] w);
        return get_cls(w) == ClsAlu;
    endfunction

    // STORE reads rs2 as its data source.
    function automatic logic reads_rs2(logic [31:0] w);
        return (get_cls(w) == ClsAlu) || (get_cls(w) == ClsStore);
    endfunction

    function automatic logic writes_rd(logic [31:0] w);
        return (get_cls(w) == ClsAlu) || (get_cls(w) == ClsLoad);
    endfunction

    // NOP (and HALT) decode to an all-zero bubble.
    function automatic dp_ctrl_t decode(logic [31:0] w);
        dp_ctrl_t c;
        c = '0;
        case (get_cls(w))
            ClsAlu: begin
                c.rs1_addr     = w[Rs1Msb:Rs1Lsb];
                c.rs2_addr     = w[Rs2Msb:Rs2Lsb];
                c.rd_addr      = w[RdMsb:RdLsb];
                c.reg_write_en = 1'b1;
                c.alu_sel      = w[AluMsb:AluLsb];
            end
            ClsLoad: begin
                c.rd_addr      = w[RdMsb:RdLsb];
                c.mem_addr     = w[AddrMsb:AddrLsb];
                c.mem_read_en  = 1'b1;
                c.reg_write_en = 1'b1;
                c.wb_data_sel  = 1'b1;
            end
            ClsStore: begin
                c.rs2_addr     = w[Rs2Msb:Rs2Lsb];
                c.mem_addr     = w[AddrMsb:AddrLsb];
                c.mem_write_en = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dp_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// dp_issue_ctrl_if
// Instruction valid/ready handshake into the issue controller.
//   instr_valid : producer has a word on instr_word
//   instr_ready : controller accepts instr_word this cycle
//   instr_word  : 32-bit instruction
// master = instruction source, slave = issue controller.
// ---------------------------------------------------------------------------
interface dp_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;

    modport master (
        output instr_valid,
        output instr_word,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_word,
        output instr_ready
    );
endinterface

// File: rtl/dp_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// dp_hazard_scoreboard
// In-flight tracking for the ISS/EX/MEM/WB slots and RAW hazard detection.
//   i_main_clk, i_main_rst : clock, synchronous active-low reset
//   i_advance              : shift the slots by one
//   i_push_*               : entry entering ISS (valid, writes-rd, rd)
//   i_cand_*               : candidate instruction and the sources it reads
//   o_hazard               : candidate source matches a pending write
//   o_busy                 : any slot occupied
//   o_drained              : ISS/EX/MEM empty (only WB may still hold work)
// ---------------------------------------------------------------------------
module dp_hazard_scoreboard #(
    parameter int unsigned SB_DEPTH = 3
) (
    input  logic       i_main_clk,
    input  logic       i_main_rst,
    input  logic       i_advance,
    input  logic       i_push_valid,
    input  logic       i_push_wen,
    input  logic [4:0] i_push_rd,
    input  logic       i_cand_valid,
    input  logic       i_cand_use_rs1,
    input  logic       i_cand_use_rs2,
    input  logic [4:0] i_cand_rs1,
    input  logic [4:0] i_cand_rs2,
    output logic       o_hazard,
    output logic       o_busy,
    output logic       o_drained
);
    localparam int unsigned NumSlots = SB_DEPTH + 1;

    // WB needs only a valid bit: its write commits this cycle, so its rd never stalls.
    logic [NumSlots-1:0] r_valid;
    logic [SB_DEPTH-1:0] r_wen;
    logic [4:0]          r_rd [SB_DEPTH];
    logic                w_hit;

    always_ff @(posedge i_main_clk) begin
        if (!i_main_rst) begin
            r_valid <= '0;
            r_wen   <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_rd[i] <= '0;
            end
        end else if (i_advance) begin
            r_valid  <= {r_valid[NumSlots-2:0], i_push_valid};
            r_wen    <= {r_wen[SB_DEPTH-2:0], i_push_wen};
            r_rd[0]  <= i_push_rd;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_rd[i] <= r_rd[i-1];
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_valid[i] && r_wen[i]) begin
                if (i_cand_use_rs1 && (i_cand_rs1 == r_rd[i])) w_hit = 1'b1;
                if (i_cand_use_rs2 && (i_cand_rs2 == r_rd[i])) w_hit = 1'b1;
            end
        end
    end

    assign o_hazard  = i_cand_valid && w_hit;
    assign o_busy    = |r_valid;
    assign o_drained = ~|r_valid[SB_DEPTH-1:0];
endmodule

// File: rtl/dp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// dp_issue_ctrl
// Instruction issue controller for the 4-stage datapath without forwarding.
//   i_main_clk, i_main_rst : clock, synchronous active-low reset
//   i_start                : pulse, leaves IDLE/DONE and clears counters
//   instr_if               : instruction valid/ready handshake (slave)
//   o_dp_*                 : registered datapath control bundle (ISS slot)
//   o_busy                 : any pipeline slot occupied
//   o_done                 : pipeline drained after HALT
//   o_issue_cnt            : accepted non-HALT instructions (saturating)
//   o_stall_cnt            : hazard-stall cycles in RUN (saturating)
// ---------------------------------------------------------------------------
module dp_issue_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SB_DEPTH = 3
) (
    input  logic             i_main_clk,
    input  logic             i_main_rst,
    input  logic             i_start,
    dp_issue_ctrl_if.slave   instr_if,
    output logic [4:0]       o_dp_rs1_addr,
    output logic [4:0]       o_dp_rs2_addr,
    output logic [4:0]       o_dp_rd_addr_wb,
    output logic             o_dp_reg_write_en_wb,
    output logic [3:0]       o_dp_alu_sel,
    output logic [7:0]       o_dp_mem_access_addr,
    output logic             o_dp_mem_write_en,
    output logic             o_dp_mem_read_en,
    output logic             o_dp_wb_data_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_issue_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           r_state;
    logic             r_done;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    dp_ctrl_t         r_ctrl;

    logic [31:0] w_word;
    logic        w_hazard;
    logic        w_drained;
    logic        w_ready;
    logic        w_accept;
    logic        w_halt;
    logic        w_advance;
    logic        w_push_wen;

    assign w_word     = instr_if.instr_word;
    assign w_halt     = is_halt(w_word);
    assign w_ready    = (r_state == StRun) && !w_hazard;
    assign w_accept   = instr_if.instr_valid && w_ready;
    assign w_advance  = (r_state != StIdle);
    assign w_push_wen = w_accept && writes_rd(w_word);

    assign instr_if.instr_ready = w_ready;

    // HALT occupies a slot (valid, no write) so DONE waits for it to leave WB.
    dp_hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .i_main_clk     (i_main_clk),
        .i_main_rst     (i_main_rst),
        .i_advance      (w_advance),
        .i_push_valid   (w_accept),
        .i_push_wen     (w_push_wen),
        .i_push_rd      (w_word[RdMsb:RdLsb]),
        .i_cand_valid   (instr_if.instr_valid),
        .i_cand_use_rs1 (reads_rs1(w_word)),
        .i_cand_use_rs2 (reads_rs2(w_word)),
        .i_cand_rs1     (w_word[Rs1Msb:Rs1Lsb]),
        .i_cand_rs2     (w_word[Rs2Msb:Rs2Lsb]),
        .o_hazard       (w_hazard),
        .o_busy         (o_busy),
        .o_drained      (w_drained)
    );

    always_ff @(posedge i_main_clk) begin
        if (!i_main_rst) begin
            r_state     <= StIdle;
            r_done      <= 1'b0;
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
            r_ctrl      <= '0;
        end else begin
            r_ctrl <= (w_accept && !w_halt) ? decode(w_word) : '0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state     <= StRun;
                        r_done      <= 1'b0;
                        r_issue_cnt <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        if (w_halt) begin
                            r_state <= StDrain;
                        end else if (r_issue_cnt != CntMax) begin
                            r_issue_cnt <= r_issue_cnt + 1'b1;
                        end
                    end
                    if (w_hazard && (r_stall_cnt != CntMax)) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                StDrain: begin
                    // Slots are empty on the same edge the WB occupant retires.
                    if (w_drained) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_dp_rs1_addr        = r_ctrl.rs1_addr;
    assign o_dp_rs2_addr        = r_ctrl.rs2_addr;
    assign o_dp_rd_addr_wb      = r_ctrl.rd_addr;
    assign o_dp_reg_write_en_wb = r_ctrl.reg_write_en;
    assign o_dp_alu_sel         = r_ctrl.alu_sel;
    assign o_dp_mem_access_addr = r_ctrl.mem_addr;
    assign o_dp_mem_write_en    = r_ctrl.mem_write_en;
    assign o_dp_mem_read_en     = r_ctrl.mem_read_en;
    assign o_dp_wb_data_sel     = r_ctrl.wb_data_sel;
    assign o_done               = r_done;
    assign o_issue_cnt          = r_issue_cnt;
    assign o_stall_cnt          = r_stall_cnt;
endmodule

// File: tb/tb_dp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dp_issue_ctrl
// Scoreboard bench: a reference model advanced on each rising edge pushes the
// expected datapath bundle into a queue; a monitor on the falling edge pops it
// and compares, together with ready/busy/done and both counters.
// The model works in edge numbers: an instruction accepted on edge k sits in
// ISS..WB for edges k..k+3, a writer blocks readers until edge k+4.
// ---------------------------------------------------------------------------
module tb_dp_issue_ctrl;
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MDrain = 2;
    localparam int MDone  = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_we, mem_we, mem_re, wb_sel;
    logic [3:0]  alu_sel;
    logic [7:0]  mem_addr;
    logic        busy, done;
    logic [15:0] issue_cnt, stall_cnt;

    dp_issue_ctrl_if u_if ();

    dp_issue_ctrl #(
        .CNT_W    (16),
        .SB_DEPTH (3)
    ) u_dut (
        .i_main_clk           (clk),
        .i_main_rst           (rst),
        .i_start              (start),
        .instr_if             (u_if),
        .o_dp_rs1_addr        (rs1_addr),
        .o_dp_rs2_addr        (rs2_addr),
        .o_dp_rd_addr_wb      (rd_addr),
        .o_dp_reg_write_en_wb (reg_we),
        .o_dp_alu_sel         (alu_sel),
        .o_dp_mem_access_addr (mem_addr),
        .o_dp_mem_write_en    (mem_we),
        .o_dp_mem_read_en     (mem_re),
        .o_dp_wb_data_sel     (wb_sel),
        .o_busy               (busy),
        .o_done               (done),
        .o_issue_cnt          (issue_cnt),
        .o_stall_cnt          (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          lw [32];
    int          last_acc = -100;
    int          halt_edge = -100;
    int          m_state = MIdle;
    int          m_issue = 0;
    int          m_stall = 0;
    bit          m_acc_last = 1'b0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Expected bundle packed as {rs1, rs2, rd, wen, alu, addr, we, re, wb_sel}.
    function automatic logic [31:0] ref_bundle(input logic [31:0] w);
        logic [4:0] rd  = w[25:21];
        logic [4:0] rs1 = w[20:16];
        logic [4:0] rs2 = w[15:11];
        logic [3:0] alu = w[29:26];
        logic [7:0] a   = w[7:0];
        case (w[31:30])
            2'b01:   return {1'b0, rs1, rs2, rd, 1'b1, alu, 8'h00, 1'b0, 1'b0, 1'b0};
            2'b10:   return {1'b0, 5'd0, 5'd0, rd, 1'b1, 4'h0, a, 1'b0, 1'b1, 1'b1};
            2'b11:   return {1'b0, 5'd0, rs2, 5'd0, 1'b0, 4'h0, a, 1'b1, 1'b0, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_halt(input logic [31:0] w);
        return (w[31:30] == 2'b00) && (w[29:26] == 4'hF);
    endfunction

    // A reader stalls while a writer of its source is within 2 edges (ISS/EX/MEM).
    function automatic bit ref_hazard(input logic v, input logic [31:0] w);
        bit use1 = (w[31:30] == 2'b01);
        bit use2 = (w[31:30] == 2'b01) || (w[31:30] == 2'b11);
        if (!v) return 1'b0;
        if (use1 && ((edge_n - lw[w[20:16]]) <= 2)) return 1'b1;
        if (use2 && ((edge_n - lw[w[15:11]]) <= 2)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model, evaluated on every rising edge.
    initial begin
        for (int i = 0; i < 32; i++) lw[i] = -100;
        forever begin
            @(posedge clk);
            if (!rst) begin
                edge_n++;
                m_state    = MIdle;
                m_issue    = 0;
                m_stall    = 0;
                last_acc   = -100;
                m_acc_last = 1'b0;
                for (int i = 0; i < 32; i++) lw[i] = -100;
                exp_q.push_back(32'h0);
            end else begin
                bit          hz;
                bit          acc;
                logic [31:0] w;
                w   = u_if.instr_word;
                hz  = ref_hazard(u_if.instr_valid, w);
                acc = u_if.instr_valid && (m_state == MRun) && !hz;
                edge_n++;
                m_acc_last = acc;
                exp_q.push_back((acc && !ref_halt(w)) ? ref_bundle(w) : 32'h0);
                if ((m_state == MRun) && hz) m_stall++;
                case (m_state)
                    MIdle, MDone: begin
                        if (start) begin
                            m_state = MRun;
                            m_issue = 0;
                            m_stall = 0;
                        end
                    end
                    MRun: begin
                        if (acc && ref_halt(w)) begin
                            m_state   = MDrain;
                            halt_edge = edge_n;
                        end
                    end
                    default: begin
                        if (edge_n == halt_edge + 4) m_state = MDone;
                    end
                endcase
                if (acc) begin
                    last_acc = edge_n;
                    if (w[31:30] == 2'b01 || w[31:30] == 2'b10) lw[w[25:21]] = edge_n;
                    if (!ref_halt(w)) m_issue++;
                end
            end
        end
    end

    // Monitor on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [31:0] exp;
                logic [31:0] got;
                exp = exp_q.pop_front();
                got = {1'b0, rs1_addr, rs2_addr, rd_addr, reg_we, alu_sel, mem_addr,
                       mem_we, mem_re, wb_sel};
                chk("dp_bundle", got, exp);
            end
            if (edge_n > 0) begin
                chk("instr_ready", {31'd0, u_if.instr_ready},
                    {31'd0, (m_state == MRun) && !ref_hazard(u_if.instr_valid,
                                                             u_if.instr_word)});
                chk("busy", {31'd0, busy}, {31'd0, (edge_n - last_acc) <= 3});
                chk("done", {31'd0, done}, {31'd0, m_state == MDone});
                chk("issue_cnt", {16'd0, issue_cnt}, m_issue);
                chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] cls, input logic [3:0] alu,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [7:0] a);
        return {cls, alu, rd, rs1, rs2, 3'b000, a};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [1:0] cls = 2'($urandom_range(0, 3));
        logic [3:0] alu = 4'($urandom_range(0, 15));
        logic [2:0] rsv = 3'($urandom_range(0, 7));
        logic [31:0] w;
        if (cls == 2'b00 && alu == 4'hF) alu = 4'h0;
        w = mk(cls, alu, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        w[10:8] = rsv;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        u_if.instr_valid = 1'b0;
        u_if.instr_word  = rand_word();
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        u_if.instr_valid = 1'b1;
        u_if.instr_word  = w;
        do begin
            step();
            n++;
        end while (!m_acc_last && n < 50);
        if (!m_acc_last) chk("send_timeout", 32'd0, 32'd1);
        u_if.instr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_state != MDone && n < 30) begin
            step();
            n++;
        end
        if (m_state != MDone) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(rand_word());
        end
    endtask

    initial begin
        logic [31:0] halt_w;
        halt_w = mk(2'b00, 4'hF, 5'd0, 5'd0, 5'd0, 8'h00);
        rst   = 1'b0;
        start = 1'b0;
        u_if.instr_valid = 1'b1;
        u_if.instr_word  = mk(2'b01, 4'h1, 5'd3, 5'd1, 5'd2, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) step();
        u_if.instr_valid = 1'b0;
        pulse_start();

        // Independent back-to-back stream.
        send(mk(2'b01, 4'h1, 5'd4, 5'd0, 5'd0, 8'h00));
        send(mk(2'b01, 4'h1, 5'd5, 5'd0, 5'd0, 8'h00));
        send(mk(2'b11, 4'h0, 5'd0, 5'd0, 5'd0, 8'h10));
        send(mk(2'b10, 4'h0, 5'd6, 5'd0, 5'd0, 8'h10));
        idle(4);

        // Distance-1 dependency.
        send(mk(2'b01, 4'h2, 5'd4, 5'd0, 5'd0, 8'h00));
        send(mk(2'b01, 4'h3, 5'd5, 5'd4, 5'd0, 8'h00));
        idle(4);

        // LOAD, NOP, dependent STORE.
        send(mk(2'b10, 4'h0, 5'd6, 5'd0, 5'd0, 8'h22));
        send(mk(2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00));
        send(mk(2'b11, 4'h0, 5'd0, 5'd0, 5'd6, 8'h23));
        idle(4);

        run_random(200);
        idle(4);

        // HALT behind two in-flight instructions.
        send(mk(2'b01, 4'h5, 5'd9, 5'd10, 5'd11, 8'h00));
        send(mk(2'b10, 4'h0, 5'd12, 5'd0, 5'd0, 8'h40));
        send(halt_w);
        wait_done();
        idle(2);
        pulse_start();

        run_random(60);
        send(halt_w);
        // Reset while draining.
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle(3);
        pulse_start();
        run_random(20);
        send(halt_w);
        wait_done();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dp_issue_ctrl.md
Name: dp_issue_ctrl

Overview:
- Instruction issue controller for the 4-stage pipelined datapath (IF/RF, EX, MEM, WB; 32x16-bit register file, 256x16-bit data memory).
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them into the datapath control bundle.
- The datapath has no forwarding, so the block detects RAW hazards with a scoreboard and inserts bubbles. It handles HALT/drain sequencing and keeps issue and stall counters.

Parameters:
- CNT_W, 16, width of issue_cnt and stall_cnt. Both counters saturate.
- SB_DEPTH, 3, number of hazard-relevant in-flight slots (ISS, EX, MEM). Fixed by the pipeline depth; not for retuning.

Ports:
- main_clk  in  1  single clock.
- main_rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE/DONE and clears counters.
- instr_valid  in  1  instr_word is valid.
- instr_ready  out  1  block accepts instr_word this cycle.
- instr_word  in  32  fields: [31:30] class (00 NOP, 01 ALU, 10 LOAD, 11 STORE); [29:26] alu_sel; [25:21] rd; [20:16] rs1; [15:11] rs2; [10:8] reserved; [7:0] mem addr. HALT = class 00 with alu_sel 4'hF.
- dp_rs1_addr  out  5  datapath read port 1 address.
- dp_rs2_addr  out  5  datapath read port 2 address.
- dp_rd_addr_wb  out  5  destination register.
- dp_reg_write_en_wb  out  1  1 for ALU and LOAD.
- dp_alu_sel  out  4  ALU operation.
- dp_mem_access_addr  out  8  memory address.
- dp_mem_write_en  out  1  1 for STORE.
- dp_mem_read_en  out  1  1 for LOAD.
- dp_wb_data_sel  out  1  1 for LOAD (memory data), 0 otherwise.
- busy  out  1  any of the ISS/EX/MEM/WB slots is occupied.
- done  out  1  high in DONE.
- issue_cnt  out  CNT_W  accepted non-HALT instructions.
- stall_cnt  out  CNT_W  hazard-stall cycles.

Behaviour:
- Reset (main_rst=0 at a main_clk edge):
  - State goes to IDLE; scoreboard is cleared.
  - All dp_* outputs, instr_ready, busy, done and both counters are 0.
  - Reset mid-operation abandons in-flight work without draining.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start goes to RUN; counters are cleared.
  - RUN: a HALT accepted goes to DRAIN.
  - DRAIN: all four slots empty goes to DONE.
  - DONE: start goes to RUN; counters are cleared.
  - start is ignored in RUN and DRAIN.
- instr_ready is combinational: state==RUN and no hazard.
- Acceptance happens on instr_valid && instr_ready.
- All dp_* outputs are registered. The decoded bundle appears in the cycle after acceptance (slot ISS = datapath IF/RF).
- Any non-accept cycle, and HALT itself, drives a bubble into ISS: all enables 0, all addresses 0, alu_sel 0.
- Decoding by class:
  - ALU: rs1, rs2, rd; wen=1; wb_sel=0.
  - LOAD: rd, addr; re=1; wen=1; wb_sel=1.
  - STORE: rs2 (data source), addr; we=1.
  - NOP: bubble.
- Scoreboard: a valid/wen/rd shift register across ISS, EX, MEM, WB. It advances every cycle in all states except IDLE.
- Hazard condition:
  - instr_valid is high, and
  - the source register the candidate uses matches rd of a wen=1 entry in ISS, EX or MEM.
  - Sources used: ALU uses rs1 and rs2; STORE uses rs2; LOAD and NOP use none.
  - A WB entry is not a hazard, because its write commits at the end of that cycle.
  - R0 gets no special treatment.
- Back-to-back dependency costs exactly 3 bubbles; distance 2 costs 2; distance 3 costs 1; distance 4 costs 0.
- stall_cnt increments on every RUN cycle with hazard=1.
- issue_cnt increments on each accepted ALU, LOAD, STORE or NOP. HALT is not counted.
- Both counters saturate at all-ones.
- busy = OR of the four slot valid bits.
- done rises in the first cycle all slots are empty after the HALT. That is 4 cycles after HALT acceptance if nothing precedes it in flight.

Decomposition:
- Package dp_ctrl_pkg holds:
  - class encodings;
  - instruction field bit positions;
  - the HALT alu_sel code (4'hF);
  - the FSM state enum;
  - the datapath control bundle struct.
- Sub-module dp_hazard_scoreboard holds the 4-slot shift register and the source/destination comparators. It outputs hazard and busy.

Test Plan:
- Reset held for 3 cycles with instr_valid=1:
  - all outputs 0 and instr_ready=0;
  - after release, state stays IDLE until start.
- start, then independent ALU R4=R0+R0, ALU R5=R0+R0, STORE [0x10] from R0, LOAD R6=[0x10], all back-to-back:
  - 4 consecutive accepts, stall_cnt=0, issue_cnt=4;
  - LOAD bundle shows re=1, wen=1, wb_sel=1, addr=0x10, rd=6.
- ALU R4, then immediately ALU R5=R4+R0:
  - instr_ready low for exactly 3 cycles and stall_cnt=3;
  - R5 appears on dp_* 4 cycles after R4.
- LOAD R6, then one independent NOP, then STORE using rs2=R6:
  - exactly 2 stall cycles.
- HALT accepted with 2 instructions in flight:
  - instr_ready drops immediately and busy stays high until the pipeline empties;
  - done rises 4 cycles after HALT;
  - start then clears the counters and re-enters RUN.
- Reset asserted in DRAIN:
  - next cycle busy=0, done=0, state IDLE;
  - counters read 0.
